// File: rtl/imm_enc_pkg.sv
// Shared types, format selector bit positions, range limits and packing helper for imm_enc.
package imm_enc_pkg;

  localparam int CNT_W_DEF = 8;

  localparam int TYPE_I_BIT = 4;
  localparam int TYPE_S_BIT = 3;
  localparam int TYPE_B_BIT = 2;
  localparam int TYPE_J_BIT = 1;
  localparam int TYPE_U_BIT = 0;

  localparam logic signed [31:0] IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IS_MAX = 32'sd2047;
  localparam logic signed [31:0] B_MIN  = -32'sd4096;
  localparam logic signed [31:0] B_MAX  = 32'sd4094;
  localparam logic signed [31:0] J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] J_MAX  = 32'sd1048574;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_U
  } fmt_e;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] imm;
    fmt_e        fmt;
    logic        err;
  } req_t;

  // Highest set selector bit wins.
  function automatic fmt_e decode_fmt(input logic [4:0] sel);
    if (sel[TYPE_I_BIT]) return FMT_I;
    if (sel[TYPE_S_BIT]) return FMT_S;
    if (sel[TYPE_B_BIT]) return FMT_B;
    if (sel[TYPE_J_BIT]) return FMT_J;
    if (sel[TYPE_U_BIT]) return FMT_U;
    return FMT_NONE;
  endfunction

  function automatic logic [31:0] pack_imm(input logic [31:0] base, input fmt_e fmt,
                                           input logic [31:0] imm);
    logic [31:0] w;
    w = base;
    case (fmt)
      FMT_I: w[31:20] = imm[11:0];
      FMT_S: begin
        w[31:25] = imm[11:5];
        w[11:7]  = imm[4:0];
      end
      FMT_B: begin
        w[31]    = imm[12];
        w[30:25] = imm[10:5];
        w[11:8]  = imm[4:1];
        w[7]     = imm[11];
      end
      FMT_J: begin
        w[31]    = imm[20];
        w[30:21] = imm[10:1];
        w[20]    = imm[11];
        w[19:12] = imm[19:12];
      end
      FMT_U:   w[31:12] = imm[31:12];
      default: w = base;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_enc_if.sv
// Request/result handshake bundle for imm_enc; slave is the encoder's view, master the requester's.
interface imm_enc_if
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) ();

  logic               in_valid_i;
  logic               in_ready_o;
  logic [31:0]        base_inst_i;
  logic [4:0]         type_i;
  logic signed [31:0] imm_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [31:0]        inst_o;
  logic               err_o;
  logic               err_clr_i;
  logic [CNT_W-1:0]   err_cnt_o;

  modport slave (
    input  in_valid_i, base_inst_i, type_i, imm_i, out_ready_i, err_clr_i,
    output in_ready_o, out_valid_o, inst_o, err_o, err_cnt_o
  );

  modport master (
    output in_valid_i, base_inst_i, type_i, imm_i, out_ready_i, err_clr_i,
    input  in_ready_o, out_valid_o, inst_o, err_o, err_cnt_o
  );

endinterface

// File: rtl/imm_range_chk.sv
// Combinational range/alignment check of an immediate against the selected format.
module imm_range_chk
  import imm_enc_pkg::*;
(
  input  fmt_e        fmt_i,
  input  logic [31:0] imm_i,
  output logic        err_o
);

  logic signed [31:0] imm_s;

  assign imm_s = $signed(imm_i);

  always_comb begin
    err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: err_o = (imm_s < IS_MIN) || (imm_s > IS_MAX);
      FMT_B:        err_o = (imm_s < B_MIN) || (imm_s > B_MAX) || imm_i[0];
      FMT_J:        err_o = (imm_s < J_MIN) || (imm_s > J_MAX) || imm_i[0];
      // Only the upper 20 bits are encodable.
      FMT_U:        err_o = |imm_i[11:0];
      default:      err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// Two-stage immediate packer: stage 1 holds request + range check, stage 2 the packed word (2-cycle latency).
// Stage 2 stalls on out_ready_i=0 and the stall ripples combinationally back to in_ready_o.
module imm_enc
  import imm_enc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input logic      clk_i,
  input logic      rst_i,
  imm_enc_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fmt_e             in_fmt;
  logic             in_err;
  logic             advance;
  logic             in_rdy;
  logic             out_xfer;

  logic             s1_vld_q, s1_vld_d;
  req_t             s1_q, s1_d;
  logic             s2_vld_q, s2_vld_d;
  logic [31:0]      s2_inst_q, s2_inst_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign in_fmt = decode_fmt(bus.type_i);

  imm_range_chk u_range_chk (
    .fmt_i (in_fmt),
    .imm_i (bus.imm_i),
    .err_o (in_err)
  );

  always_comb begin
    advance   = !s2_vld_q || bus.out_ready_i;
    in_rdy    = !rst_i && (!s1_vld_q || advance);
    out_xfer  = s2_vld_q && bus.out_ready_i;

    s1_vld_d  = s1_vld_q;
    s1_d      = s1_q;
    s2_vld_d  = s2_vld_q;
    s2_inst_d = s2_inst_q;
    s2_err_d  = s2_err_q;
    err_cnt_d = err_cnt_q;

    // in_rdy implies stage 1 is empty or being drained this cycle.
    if (in_rdy) begin
      s1_vld_d = bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_d.base = bus.base_inst_i;
        s1_d.imm  = bus.imm_i;
        s1_d.fmt  = in_fmt;
        s1_d.err  = in_err;
      end
    end

    if (advance) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_inst_d = pack_imm(s1_q.base, s1_q.fmt, s1_q.imm);
        s2_err_d  = s1_q.err;
      end
    end

    if (bus.err_clr_i) begin
      err_cnt_d = '0;
    end else if (out_xfer && s2_err_q && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_q      <= '0;
      s2_vld_q  <= 1'b0;
      s2_inst_q <= '0;
      s2_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_q      <= s1_d;
      s2_vld_q  <= s2_vld_d;
      s2_inst_q <= s2_inst_d;
      s2_err_q  <= s2_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_valid_o = s2_vld_q;
  assign bus.inst_o      = s2_inst_q;
  assign bus.err_o       = s2_err_q;
  assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_imm_enc.sv
// Bench for imm_enc: directed cases plus random traffic, scoreboard fed at acceptance and drained by a monitor.
`timescale 1ns/1ps
module tb_imm_enc;

  localparam int CNT_W   = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  imm_enc_if #(.CNT_W(CNT_W)) bus ();

  imm_enc #(.CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
    int          fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_in, e_out;
  int          n_chk = 0;
  int          n_fail = 0;
  int          acc_cnt = 0;
  int          exp_cnt = 0;
  logic        rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] inst_prev;
  logic        err_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // 0 = pass-through, 1..5 = I,S,B,J,U
  function automatic int fmt_of(input logic [4:0] t);
    if (t[4]) return 1;
    if (t[3]) return 2;
    if (t[2]) return 3;
    if (t[1]) return 4;
    if (t[0]) return 5;
    return 0;
  endfunction

  // Immediate bit that lands on instruction bit p, or -1 when the base bit is kept.
  function automatic int src_bit(input int f, input int p);
    case (f)
      1: if (p >= 20) return p - 20;
      2: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
      end
      3: begin
        if (p == 31) return 12;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
        if (p == 7) return 11;
      end
      4: begin
        if (p == 31) return 20;
        if (p >= 21) return p - 20;
        if (p == 20) return 11;
        if (p >= 12) return p;
      end
      5: if (p >= 12) return p;
      default: ;
    endcase
    return -1;
  endfunction

  function automatic logic [31:0] ref_pack(input logic [31:0] base, input int f, input logic [31:0] imm);
    logic [31:0] w;
    int s;
    w = base;
    for (int p = 0; p < 32; p++) begin
      s = src_bit(f, p);
      if (s >= 0) w[p] = imm[s];
    end
    return w;
  endfunction

  function automatic logic ref_err(input int f, input logic [31:0] imm);
    longint v;
    v = $signed(imm);
    case (f)
      1, 2:    return (v < -2048) || (v > 2047);
      3:       return (v < -4096) || (v > 4094) || imm[0];
      4:       return (v < -1048576) || (v > 1048574) || imm[0];
      5:       return imm[11:0] != 12'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_unpack(input logic [31:0] inst, input int f);
    logic [31:0] r;
    int s;
    int top;
    r = '0;
    top = (f == 3) ? 12 : (f == 4) ? 20 : (f == 5) ? 31 : 11;
    for (int p = 0; p < 32; p++) begin
      s = src_bit(f, p);
      if (s >= 0) r[s] = inst[p];
    end
    for (int b = top + 1; b < 32; b++) r[b] = r[top];
    return r;
  endfunction

  function automatic logic [31:0] gen_imm(input int f);
    int lo, hi;
    int m;
    logic [31:0] r;
    m = int'($urandom_range(0, 5));
    r = $urandom;
    case (f)
      1, 2: begin lo = -2048;    hi = 2047;    end
      3:    begin lo = -4096;    hi = 4094;    end
      4:    begin lo = -1048576; hi = 1048574; end
      default: return (m < 3) ? (r & 32'hFFFF_F000) : r;
    endcase
    case (m)
      0: return r;
      1: return lo;
      2: return hi;
      3: return ($urandom_range(0, 1) != 0) ? hi + 1 : lo - 1;
      default: begin
        r = lo + int'($urandom_range(0, hi - lo));
        return (f >= 3) ? (r & ~32'd1) : r;
      end
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_cnt    = 0;
      stall_prev = 1'b0;
    end else begin
      chk("err_cnt", bus.err_cnt_o, exp_cnt);
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid_o, 1);
        chk("hold_inst", bus.inst_o, inst_prev);
        chk("hold_err", bus.err_o, err_prev);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL spurious_out: got inst 0x%08h with no request pending", bus.inst_o);
        end else begin
          e_out = sb.pop_front();
          chk("sb_inst", bus.inst_o, e_out.inst);
          chk("sb_err", bus.err_o, e_out.err);
          if (!e_out.err && e_out.fmt != 0)
            chk("roundtrip", ref_unpack(bus.inst_o, e_out.fmt), e_out.imm);
          if (bus.err_clr_i) exp_cnt = 0;
          else if (e_out.err && exp_cnt < CNT_SAT) exp_cnt++;
        end
      end else if (bus.err_clr_i) begin
        exp_cnt = 0;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        e_in.fmt  = fmt_of(bus.type_i);
        e_in.imm  = bus.imm_i;
        e_in.err  = ref_err(e_in.fmt, bus.imm_i);
        e_in.inst = ref_pack(bus.base_inst_i, e_in.fmt, bus.imm_i);
        sb.push_back(e_in);
        acc_cnt++;
      end
      stall_prev = bus.out_valid_o && !bus.out_ready_i;
      inst_prev  = bus.inst_o;
      err_prev   = bus.err_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      bus.out_ready_i = ($urandom_range(0, 9) < 7);
      bus.err_clr_i   = ($urandom_range(0, 31) == 0);
    end
  endtask

  task automatic send(input logic [31:0] base, input logic [4:0] t, input logic [31:0] imm);
    logic acc;
    bus.in_valid_i  = 1'b1;
    bus.base_inst_i = base;
    bus.type_i      = t;
    bus.imm_i       = imm;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      acc = bus.in_ready_o;
      cyc();
      if (acc) begin
        bus.in_valid_i = 1'b0;
        return;
      end
    end
    bus.in_valid_i = 1'b0;
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout: in_ready_o stayed 0, required 1 within 1000 cycles");
  endtask

  task automatic wait_out(input string name, input logic [31:0] inst, input logic chk_inst, input logic err);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (chk_inst) chk({name, "_inst"}, bus.inst_o, inst);
        chk({name, "_err"}, bus.err_o, err);
        cyc();
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL %s_timeout: out_valid_o stayed 0, required 1 within 50 cycles", name);
  endtask

  task automatic drain();
    bus.out_ready_i = 1'b1;
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int a0;
    logic [31:0] r1_exp;

    bus.in_valid_i  = 1'b0;
    bus.base_inst_i = '0;
    bus.type_i      = '0;
    bus.imm_i       = '0;
    bus.out_ready_i = 1'b0;
    bus.err_clr_i   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_inst", bus.inst_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_err_cnt", bus.err_cnt_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready_o, 1);
    cyc();

    // I format and latency
    bus.out_ready_i = 1'b1;
    send(32'h0000_0013, 5'b10000, -32'sd1);
    @(negedge clk);
    chk("lat_not_yet", bus.out_valid_o, 0);
    @(negedge clk);
    chk("lat_valid", bus.out_valid_o, 1);
    chk("i_inst", bus.inst_o, 32'hFFF0_0013);
    chk("i_err", bus.err_o, 0);
    cyc();

    // B and J formats
    send(32'h0000_0063, 5'b00100, -32'sd4);
    wait_out("b_neg4", 32'hFE00_0EE3, 1'b1, 1'b0);
    send(32'h0000_0063, 5'b00100, 32'd3);
    wait_out("b_odd", 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("b_odd_cnt", bus.err_cnt_o, 1);
    cyc();
    send(32'h0000_006F, 5'b00010, 32'd2048);
    wait_out("j_2048", 32'h0010_006F, 1'b1, 1'b0);

    // U format and pass-through
    send(32'h0000_0037, 5'b00001, 32'h1234_5000);
    wait_out("u_ok", 32'h1234_5037, 1'b1, 1'b0);
    send(32'h0000_0037, 5'b00001, 32'h1234_5001);
    wait_out("u_low", 32'h1234_5037, 1'b1, 1'b1);
    send(32'hDEAD_BEEF, 5'b00000, 32'd123);
    wait_out("none", 32'hDEAD_BEEF, 1'b1, 1'b0);

    // Backpressure: two accepted, the third held off
    bus.out_ready_i = 1'b0;
    a0 = acc_cnt;
    r1_exp = ref_pack(32'h0000_0013, 1, 32'd100);
    send(32'h0000_0013, 5'b10000, 32'd100);
    send(32'h0000_0023, 5'b01000, -32'sd5);
    bus.in_valid_i  = 1'b1;
    bus.base_inst_i = 32'h0000_006F;
    bus.type_i      = 5'b00010;
    bus.imm_i       = -32'sd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready_o, 0);
      chk("bp_out_valid", bus.out_valid_o, 1);
      chk("bp_inst", bus.inst_o, r1_exp);
      cyc();
    end
    chk("bp_accepted", acc_cnt - a0, 2);
    bus.out_ready_i = 1'b1;
    send(32'h0000_006F, 5'b00010, -32'sd2);
    drain();

    // Counter saturation, then clear winning over an increment
    for (int k = 0; k < 300; k++) send(32'h0000_0037, 5'b00001, 32'h0000_0ABC);
    drain();
    @(negedge clk);
    chk("cnt_sat", bus.err_cnt_o, CNT_SAT);
    cyc();
    bus.out_ready_i = 1'b0;
    send(32'h0000_0013, 5'b10000, 32'd5000);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid_o) break;
    end
    cyc();
    bus.out_ready_i = 1'b1;
    bus.err_clr_i   = 1'b1;
    @(negedge clk);
    chk("clr_xfer_err", bus.err_o, 1);
    cyc();
    bus.err_clr_i = 1'b0;
    @(negedge clk);
    chk("cnt_clr", bus.err_cnt_o, 0);
    cyc();

    // Random traffic
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [4:0] t;
      repeat ($urandom_range(0, 2)) cyc();
      t = 5'($urandom_range(0, 31));
      send($urandom, t, gen_imm(fmt_of(t)));
    end
    rand_rdy = 1'b0;
    bus.err_clr_i = 1'b0;
    drain();

    // Reset with both stages full
    bus.out_ready_i = 1'b0;
    send(32'h0000_0013, 5'b10000, 32'd7);
    send(32'h0000_0063, 5'b00100, 32'd8);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid_o, 0);
    chk("mid_rst_in_ready", bus.in_ready_o, 0);
    @(negedge clk);
    chk("mid_rst_inst", bus.inst_o, 0);
    chk("mid_rst_cnt", bus.err_cnt_o, 0);
    cyc();
    cyc();
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready_o, 1);
    chk("post_rst_out_valid", bus.out_valid_o, 0);
    for (int k = 0; k < 5; k++) begin
      cyc();
      @(negedge clk);
      chk("no_stale_out", bus.out_valid_o, 0);
    end
    cyc();
    send(32'h0000_0023, 5'b01000, -32'sd2048);
    wait_out("post_rst_s", ref_pack(32'h0000_0023, 2, -32'sd2048), 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
